// File: rtl/cache_rd_refill.sv
`default_nettype none
// ============================================================================
// Module   : cache_rd_refill
// Brief    : Parametrised direct-mapped read cache. Hits return a word one
//            cycle after acceptance. Misses issue a line refill to memory
//            and return the word in a one-cycle RESP state. Also provides
//            a flush and saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_rd_refill #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         ready,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         flush,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = LINE_WORDS * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic                 fill;

  // Line storage; contents are only meaningful where the valid bit is set.
  logic [LINE_W-1:0]    data_q [LINES];
  logic [TAG_W-1:0]     tag_q  [LINES];

  // Request address fields
  logic [OFF_W-1:0]     w_off;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic [LINE_WORDS-1:0][DATA_W-1:0] w_line_words;
  logic [LINE_WORDS-1:0][DATA_W-1:0] w_mem_words;

  // The refill target is taken from the latched line address, not req_addr.
  logic [IDX_W-1:0]     w_fill_idx;
  logic [TAG_W-1:0]     w_fill_tag;

  assign w_off        = req_addr[OFF_W-1:0];
  assign w_idx        = req_addr[OFF_W +: IDX_W];
  assign w_tag        = req_addr[ADDR_W-1 -: TAG_W];
  assign w_hit        = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_line_words = data_q[w_idx];
  assign w_mem_words  = mem_data;
  assign w_fill_idx   = mem_addr_q[OFF_W +: IDX_W];
  assign w_fill_tag   = mem_addr_q[ADDR_W-1 -: TAG_W];

  assign ready      = (state_q == S_IDLE) && !flush;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Next-state, lookup and refill control
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    off_d      = off_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // Flush takes priority over any request presented in the same cycle.
          valid_d = '0;
        end else if (req) begin
          if (w_hit) begin
            rd_valid_d = 1'b1;
            rd_data_d  = w_line_words[w_off];
            if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            off_d      = w_off;
            if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
            state_d    = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          // The requested word is registered now, so it appears in RESP.
          fill                = 1'b1;
          valid_d[w_fill_idx] = 1'b1;
          mem_req_d           = 1'b0;
          rd_valid_d          = 1'b1;
          rd_data_d           = w_mem_words[off_q];
          state_d             = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and counters, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      off_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      off_q      <= off_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Data and tag arrays, written on refill only
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[w_fill_idx] <= mem_data;
      tag_q[w_fill_idx]  <= w_fill_tag;
    end
  end

endmodule
`default_nettype wire
